// File: rtl/bomberman_pkg.sv
// Shared types and helpers for the bomberman player path.
package bomberman_pkg;

  localparam int unsigned NUM_DIRS = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic logic [NUM_DIRS-1:0] dir2onehot(input dir_e d);
    logic [NUM_DIRS-1:0] oh;
    case (d)
      DIR_UP:    oh = 4'b1000;
      DIR_DOWN:  oh = 4'b0100;
      DIR_LEFT:  oh = 4'b0010;
      default:   oh = 4'b0001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debounce; rise pulses with the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; flip on the last one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Player input front end: debounced buttons, last-pressed direction arbiter,
// facing register, free-running movement tick and bomb request pulse.
module player_input_ctrl
  import bomberman_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 1_666_667
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_bomb,
  output logic [NUM_DIRS-1:0] move_dir,
  output logic                tick,
  output logic [1:0]          face_dir,
  output logic                bomb_req
);

  localparam int unsigned NUM_BTNS = NUM_DIRS + 1;
  localparam int unsigned TICK_W   = $clog2(TICK_CYCLES);

  logic [NUM_BTNS-1:0] raw, stable, rise;
  logic [NUM_DIRS-1:0] lvl, dir_rise;

  // Bit order matches move_dir: up, down, left, right, then bomb at bit 0.
  assign raw = {btn_up, btn_down, btn_left, btn_right, btn_bomb};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[i]),
      .stable (stable[i]),
      .rise   (rise[i])
    );
  end

  assign lvl      = stable[NUM_BTNS-1:1];
  assign dir_rise = rise[NUM_BTNS-1:1];

  function automatic dir_e pri_pick(input logic [NUM_DIRS-1:0] v);
    if (v[3])      return DIR_UP;
    else if (v[2]) return DIR_DOWN;
    else if (v[1]) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

  dir_e                active_q, active_d;
  logic                valid_q, valid_d;
  dir_e                face_q, face_d;
  logic [NUM_DIRS-1:0] move_dir_q, move_dir_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                tick_q, tick_d;
  logic                bomb_req_q, bomb_req_d;

  // New presses take over; a released active direction hands off to the best held one.
  always_comb begin
    active_d   = active_q;
    valid_d    = valid_q;
    if (|dir_rise) begin
      active_d = pri_pick(dir_rise);
      valid_d  = 1'b1;
    end else if (valid_q && ((lvl & dir2onehot(active_q)) == '0)) begin
      active_d = pri_pick(lvl);
      valid_d  = |lvl;
    end
    move_dir_d = valid_d ? dir2onehot(active_d) : '0;
    face_d     = valid_d ? active_d : face_q;
    tick_d     = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + TICK_W'(1);
    bomb_req_d = rise[0] & stable[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= DIR_UP;
      valid_q    <= 1'b0;
      face_q     <= DIR_DOWN;
      move_dir_q <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      bomb_req_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      valid_q    <= valid_d;
      face_q     <= face_d;
      move_dir_q <= move_dir_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      bomb_req_q <= bomb_req_d;
    end
  end

  assign move_dir = move_dir_q;
  assign face_dir = face_q;
  assign tick     = tick_q;
  assign bomb_req = bomb_req_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with short debounce and tick periods.
module tb_player_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_bomb;
  logic [3:0] move_dir;
  logic       tick;
  logic [1:0] face_dir;
  logic       bomb_req;

  int checks   = 0;
  int failures = 0;

  player_input_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_bomb  (btn_bomb),
    .move_dir  (move_dir),
    .tick      (tick),
    .face_dir  (face_dir),
    .bomb_req  (bomb_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int pulses;
  int pulse_at;

  initial begin
    rst = 1'b1;
    {btn_up, btn_down, btn_left, btn_right, btn_bomb} = '0;
    step(3);
    check("rst_move_dir", 32'(move_dir), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_face", 32'(face_dir), 32'h1);
    check("rst_bomb", 32'(bomb_req), 32'h0);

    // 1: free-running tick after reset release
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      check($sformatf("tick_k%0d", k), 32'(tick), (k % 8 == 0) ? 32'h1 : 32'h0);
    end

    // 2: bouncing UP must not register; final hold appears after 7 cycles
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      step(2);
      check("bounce_quiet", 32'(move_dir), 32'h0);
    end
    btn_up = 1'b1;
    step(6);
    check("up_k6", 32'(move_dir), 32'h0);
    step(1);
    check("up_k7", 32'(move_dir), 32'h8);
    check("up_face", 32'(face_dir), 32'h0);

    btn_up = 1'b0;
    step(10);
    check("idle_move", 32'(move_dir), 32'h0);
    check("idle_face_hold", 32'(face_dir), 32'h0);

    // 3: last-pressed wins, handoff on release
    btn_left = 1'b1;
    step(7);
    check("left", 32'(move_dir), 32'h2);
    check("left_face", 32'(face_dir), 32'h2);
    btn_up = 1'b1;
    step(7);
    check("up_over_left", 32'(move_dir), 32'h8);
    btn_up = 1'b0;
    step(6);
    check("up_rel_k6", 32'(move_dir), 32'h8);
    step(1);
    check("back_to_left", 32'(move_dir), 32'h2);
    btn_left = 1'b0;
    step(7);
    check("none", 32'(move_dir), 32'h0);
    check("none_face", 32'(face_dir), 32'h2);

    // 4: simultaneous DOWN+RIGHT, then release DOWN
    btn_down  = 1'b1;
    btn_right = 1'b1;
    step(7);
    check("down_pri", 32'(move_dir), 32'h4);
    check("down_face", 32'(face_dir), 32'h1);
    btn_down = 1'b0;
    step(7);
    check("right_after", 32'(move_dir), 32'h1);
    check("right_face", 32'(face_dir), 32'h3);

    // 5: bomb pulses, one per press, 7 cycles after the press edge
    btn_bomb = 1'b1;
    pulses   = 0;
    pulse_at = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (bomb_req) begin
        pulses++;
        pulse_at = k;
      end
    end
    check("bomb1_count", 32'(pulses), 32'd1);
    check("bomb1_at", 32'(pulse_at), 32'd7);
    btn_bomb = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (bomb_req) pulses++;
    end
    check("bomb_release_quiet", 32'(pulses), 32'd1);
    btn_bomb = 1'b1;
    pulse_at = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (bomb_req) begin
        pulses++;
        pulse_at = k;
      end
    end
    check("bomb_total", 32'(pulses), 32'd2);
    check("bomb2_at", 32'(pulse_at), 32'd7);
    btn_bomb = 1'b0;

    // 6: one-cycle reset while RIGHT held
    check("pre_rst_right", 32'(move_dir), 32'h1);
    rst = 1'b1;
    step(1);
    check("rst6_move", 32'(move_dir), 32'h0);
    check("rst6_face", 32'(face_dir), 32'h1);
    check("rst6_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check($sformatf("rst6_move_k%0d", k), 32'(move_dir), (k >= 7) ? 32'h1 : 32'h0);
      check($sformatf("rst6_tick_k%0d", k), 32'(tick), (k == 8) ? 32'h1 : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
